// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the VGA pixel-write port between two round-robin requesters and a full-screen clear engine.
module vga_plot_arbiter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       req_a,
    input  logic       last_a,
    input  logic [8:0] x_a,
    input  logic [6:0] y_a,
    input  logic [2:0] colour_a,
    output logic       grant_a,
    input  logic       req_b,
    input  logic       last_b,
    input  logic [8:0] x_b,
    input  logic [6:0] y_b,
    input  logic [2:0] colour_b,
    output logic       grant_b,
    input  logic       clear_start,
    output logic       clear_busy,
    output logic       clear_done,
    output logic       plot,
    output logic [8:0] x,
    output logic [6:0] y,
    output logic [2:0] colour
);
    typedef enum logic [1:0] {IDLE, BURST_A, BURST_B, CLEAR} state_t;
    localparam logic [8:0] XMAX = 9'(SCREEN_W - 1);
    localparam logic [6:0] YMAX = 7'(SCREEN_H - 1);
    state_t state_q, state_d;
    logic last_b_q, last_b_d;
    logic pending_q, pending_d;
    logic wrap_q, wrap_d;
    logic [8:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic grant_a_q, grant_b_q;
    logic plot_q, plot_d;
    logic [8:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic done_q, done_d;
    logic sel_b, req_k, last_k, clr_last;
    logic [8:0] x_k;
    logic [6:0] y_k;
    logic [2:0] colour_k;
    assign sel_b    = state_q == BURST_B;
    assign req_k    = sel_b ? req_b : req_a;
    assign last_k   = sel_b ? last_b : last_a;
    assign x_k      = sel_b ? x_b : x_a;
    assign y_k      = sel_b ? y_b : y_a;
    assign colour_k = sel_b ? colour_b : colour_a;
    assign clr_last = cx_q == XMAX && cy_q == YMAX;
    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        pending_d = pending_q | (clear_start & (state_q != CLEAR));
        wrap_d    = wrap_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        plot_d    = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q || clear_start) state_d = CLEAR;
                else if (req_a && (!req_b || last_b_q)) state_d = BURST_A;
                else if (req_b) state_d = BURST_B;
            end
            BURST_A, BURST_B: begin
                if (req_k && x_k <= XMAX && y_k <= YMAX) begin
                    plot_d   = 1'b1;
                    x_d      = x_k;
                    y_d      = y_k;
                    colour_d = colour_k;
                end
                if (!req_k || last_k) begin
                    state_d  = IDLE;
                    last_b_d = sel_b;
                end
            end
            default: begin
                // Final cycle lets the last clear pixel reach the output before clear_done fires.
                if (wrap_q) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                    wrap_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    plot_d   = 1'b1;
                    x_d      = cx_q;
                    y_d      = cy_q;
                    colour_d = CLEAR_COLOUR;
                    cx_d     = cx_q == XMAX ? 9'd0 : cx_q + 9'd1;
                    cy_d     = cx_q == XMAX ? (clr_last ? 7'd0 : cy_q + 7'd1) : cy_q;
                    wrap_d   = clr_last;
                end
            end
        endcase
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            pending_q <= 1'b0;
            wrap_q    <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            plot_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            pending_q <= pending_d;
            wrap_q    <= wrap_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            grant_a_q <= state_d == BURST_A;
            grant_b_q <= state_d == BURST_B;
            plot_q    <= plot_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            done_q    <= done_d;
        end
    end
    assign grant_a    = grant_a_q;
    assign grant_b    = grant_b_q;
    assign clear_busy = pending_q;
    assign clear_done = done_q;
    assign plot       = plot_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed checks of bursts, round robin, deferred clear, off-screen pixels and reset mid-clear.
module tb_vga_plot_arbiter;
    logic clk = 1'b0;
    logic reset, req_a, last_a, req_b, last_b, clear_start;
    logic [8:0] x_a, x_b, x;
    logic [6:0] y_a, y_b, y;
    logic [2:0] colour_a, colour_b, colour;
    logic grant_a, grant_b, clear_busy, clear_done, plot;
    int total = 0;
    int bad = 0;

    vga_plot_arbiter dut (
        .CLOCK_50(clk), .reset(reset),
        .req_a(req_a), .last_a(last_a), .x_a(x_a), .y_a(y_a), .colour_a(colour_a), .grant_a(grant_a),
        .req_b(req_b), .last_b(last_b), .x_b(x_b), .y_b(y_b), .colour_b(colour_b), .grant_b(grant_b),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .plot(plot), .x(x), .y(y), .colour(colour)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt, errs, ex, ey, lx, ly;
        bit seen;
        reset = 1; req_a = 0; last_a = 0; req_b = 0; last_b = 0; clear_start = 0;
        x_a = 0; y_a = 0; colour_a = 0; x_b = 0; y_b = 0; colour_b = 0;
        step(); step();
        reset = 0;
        chk("rst_plot", plot, 0); chk("rst_ga", grant_a, 0); chk("rst_gb", grant_b, 0);
        chk("rst_busy", clear_busy, 0); chk("rst_done", clear_done, 0);
        chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_colour", colour, 0);
        errs = 0;
        repeat (10) begin
            step();
            if (plot || grant_a || grant_b || clear_busy || clear_done) errs++;
        end
        chk("idle_quiet", errs, 0);

        // single A burst
        req_a = 1; x_a = 10; y_a = 5; colour_a = 2;
        step();
        chk("burst_grant", grant_a, 1); chk("burst_noplot", plot, 0);
        for (int i = 0; i < 3; i++) begin
            y_a = 7'(5 + i); last_a = (i == 2);
            step();
            chk("burst_plot", plot, 1); chk("burst_x", x, 10);
            chk("burst_y", y, 5 + i); chk("burst_colour", colour, 2);
        end
        chk("burst_grant_fall", grant_a, 0);
        req_a = 0; last_a = 0;
        step();
        chk("burst_after_plot", plot, 0);

        // round robin from a fresh reset
        reset = 1; step(); reset = 0;
        req_a = 1; last_a = 1; x_a = 1; y_a = 1; colour_a = 1;
        req_b = 1; last_b = 1; x_b = 2; y_b = 2; colour_b = 3;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_ga", grant_a, (i % 2) == 0); chk("rr_gb", grant_b, (i % 2) == 1);
            chk("rr_wait_plot", plot, 0);
            step();
            chk("rr_bubble_ga", grant_a, 0); chk("rr_bubble_gb", grant_b, 0);
            chk("rr_plot", plot, 1); chk("rr_x", x, (i % 2) ? 2 : 1);
        end
        req_a = 0; req_b = 0;

        // deferred clear: A burst of 5 with B waiting
        req_a = 1; last_a = 0; x_a = 20; y_a = 30; colour_a = 5;
        req_b = 1; last_b = 1;
        step();
        chk("dc_grant_a", grant_a, 1); chk("dc_grant_b", grant_b, 0);
        for (int i = 0; i < 5; i++) begin
            x_a = 9'(20 + i); last_a = (i == 4); clear_start = (i == 1);
            step();
            clear_start = 0;
            chk("dc_plot", plot, 1); chk("dc_x", x, 20 + i);
            if (i >= 1) chk("dc_busy", clear_busy, 1);
        end
        chk("dc_grant_a_fall", grant_a, 0);
        req_a = 0; last_a = 0;
        step();
        chk("dc_enter_plot", plot, 0); chk("dc_enter_gb", grant_b, 0); chk("dc_enter_busy", clear_busy, 1);
        cnt = 0; errs = 0; ex = 0; ey = 0; lx = -1; ly = -1; seen = 0;
        for (int n = 0; n < 20000 && !seen; n++) begin
            step();
            if (grant_a || grant_b) errs++;
            if (clear_done) seen = 1;
            else begin
                if (!clear_busy) errs++;
                if (plot) begin
                    if (x !== 9'(ex) || y !== 7'(ey) || colour !== 3'd0) errs++;
                    lx = x; ly = y; cnt++;
                    ex = (ex == 159) ? 0 : ex + 1;
                    if (ex == 0) ey++;
                end
            end
        end
        chk("clear_done_seen", seen, 1); chk("clear_count", cnt, 19200);
        chk("clear_last_x", lx, 159); chk("clear_last_y", ly, 119);
        chk("clear_scan", errs, 0); chk("clear_done_busy", clear_busy, 0); chk("clear_done_plot", plot, 0);
        step();
        chk("clear_done_pulse", clear_done, 0); chk("after_clear_gb", grant_b, 1); chk("after_clear_ga", grant_a, 0);
        step();
        chk("b_plot", plot, 1); chk("b_x", x, 2); chk("b_y", y, 2); chk("b_colour", colour, 3);
        chk("b_grant_fall", grant_b, 0);
        req_b = 0; last_b = 0;

        // off-screen pixels
        req_a = 1; x_a = 160; y_a = 0; colour_a = 4;
        step();
        chk("off_grant", grant_a, 1);
        step();
        chk("off_x_plot", plot, 0); chk("off_x_hold", x, 2);
        x_a = 5; y_a = 120;
        step();
        chk("off_y_plot", plot, 0);
        x_a = 159; y_a = 119; colour_a = 6; last_a = 1;
        step();
        chk("edge_plot", plot, 1); chk("edge_x", x, 159); chk("edge_y", y, 119);
        chk("edge_colour", colour, 6); chk("edge_grant_fall", grant_a, 0);
        req_a = 0; last_a = 0;
        step();

        // reset in the middle of a clear
        clear_start = 1;
        step();
        clear_start = 0;
        chk("mc_busy", clear_busy, 1);
        repeat (500) step();
        chk("mc_plotting", plot, 1);
        reset = 1;
        step();
        reset = 0;
        chk("mc_rst_plot", plot, 0); chk("mc_rst_busy", clear_busy, 0); chk("mc_rst_done", clear_done, 0);
        errs = 0;
        repeat (3) begin
            step();
            if (clear_done || plot || clear_busy) errs++;
        end
        chk("mc_quiet", errs, 0);
        req_a = 1; last_a = 1; x_a = 7; y_a = 8; colour_a = 1;
        step();
        chk("mc_grant", grant_a, 1);
        step();
        chk("mc_plot", plot, 1); chk("mc_x", x, 7); chk("mc_y", y, 8); chk("mc_colour", colour, 1);
        req_a = 0; last_a = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
